// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the two-port SRAM arbiter
package ram_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] GNT_M0 = 2'b01;
    localparam logic [1:0] GNT_M1 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker, one-hot winner
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    // last=1 means m1 was served most recently, so a tie goes to m0
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = GNT_M0;
            2'b10:   win = GNT_M1;
            2'b11:   win = last ? GNT_M0 : GNT_M1;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing the ram bus between fetch (m0) and data (m1)
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,

    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    input  logic              bus_ack_i,

    output logic [1:0]        grant
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_q;
    logic [7:0]        cnt_q;
    logic [1:0]        req, win;
    logic              tmo, fin, owner_m1;
    logic [DATA_W-1:0] fin_rdata;

    assign req = {m1_req, m0_req};

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

    assign owner_m1 = (grant == GNT_M1);
    assign tmo      = (cnt_q == TMO_LAST);
    assign fin      = (state_q == BUSY) && (bus_ack_i || tmo);
    // an ack on the timeout edge still wins; writes and aborts return zero
    assign fin_rdata = (bus_ack_i && !bus_we_o) ? bus_data_i : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = BUSY;
            BUSY:    if (bus_ack_i || tmo) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= 1'b1;
            cnt_q      <= '0;
            grant      <= 2'b00;
            bus_addr_o <= '0;
            bus_data_o <= '0;
            bus_ce_o   <= 1'b0;
            bus_we_o   <= 1'b0;
            m0_rdata   <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|win) begin
                        grant      <= win;
                        cnt_q      <= '0;
                        bus_ce_o   <= 1'b1;
                        bus_addr_o <= win[1] ? m1_addr  : m0_addr;
                        bus_data_o <= win[1] ? m1_wdata : m0_wdata;
                        bus_we_o   <= win[1] ? m1_we    : m0_we;
                    end
                end
                BUSY: begin
                    if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                    if (fin) begin
                        bus_ce_o   <= 1'b0;
                        bus_we_o   <= 1'b0;
                        bus_addr_o <= '0;
                        bus_data_o <= '0;
                        last_q     <= owner_m1;
                        if (owner_m1) begin
                            m1_ack   <= 1'b1;
                            m1_err   <= !bus_ack_i;
                            m1_rdata <= fin_rdata;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_err   <= !bus_ack_i;
                            m0_rdata <= fin_rdata;
                        end
                    end
                end
                DONE: begin
                    grant <= 2'b00;
                end
                default: begin
                    grant    <= 2'b00;
                    bus_ce_o <= 1'b0;
                    bus_we_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a planned ram responder
module tb_ram_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] bus_addr_o, bus_data_o, bus_data_i;
    logic        bus_ce_o, bus_we_o, bus_ack_i;
    logic [1:0]  grant;

    ram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_we      (m0_we),
        .m0_rdata   (m0_rdata),
        .m0_ack     (m0_ack),
        .m0_err     (m0_err),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_we      (m1_we),
        .m1_rdata   (m1_rdata),
        .m1_ack     (m1_ack),
        .m1_err     (m1_err),
        .bus_addr_o (bus_addr_o),
        .bus_data_o (bus_data_o),
        .bus_data_i (bus_data_i),
        .bus_ce_o   (bus_ce_o),
        .bus_we_o   (bus_we_o),
        .bus_ack_i  (bus_ack_i),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    // lat = BUSY cycles before the ram acks; lat >= TIMEOUT means it never acks
    typedef struct {
        bit          owner;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rd;
        bit          we;
        int          lat;
    } txn_t;

    txn_t plan_q[$];
    txn_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   ram_en = 1'b0;
    bit   last_srv = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input txn_t t);
        return (t.lat >= TIMEOUT || t.we) ? 32'h0 : t.bus_rd;
    endfunction

    function automatic txn_t mk(input bit owner, input logic [31:0] addr, input logic [31:0] wdata,
                                input bit we, input logic [31:0] bus_rd, input int lat);
        txn_t t;
        t.owner = owner; t.addr = addr; t.wdata = wdata;
        t.we = we; t.bus_rd = bus_rd; t.lat = lat;
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit owner);
        int lat;
        case ($urandom_range(0, 5))
            0:       lat = 0;
            1:       lat = TIMEOUT - 1;
            2:       lat = TIMEOUT + 3;
            default: lat = int'($urandom_range(1, 6));
        endcase
        return mk(owner, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, lat);
    endfunction

    task automatic push(input txn_t t);
        plan_q.push_back(t);
        exp_q.push_back(t);
    endtask

    // called at a negedge; holds requests until acked, scrambling the owner's inputs mid-BUSY
    task automatic run_round(input bit h0, input bit h1, input txn_t t0, input txn_t t1);
        if (h0 && h1) begin
            if (last_srv) begin push(t0); push(t1); last_srv = 1'b1; end
            else          begin push(t1); push(t0); last_srv = 1'b0; end
        end else if (h0) begin
            push(t0); last_srv = 1'b0;
        end else if (h1) begin
            push(t1); last_srv = 1'b1;
        end
        m0_req = h0; m0_addr = t0.addr; m0_wdata = t0.wdata; m0_we = t0.we;
        m1_req = h1; m1_addr = t1.addr; m1_wdata = t1.wdata; m1_we = t1.we;
        for (int cyc = 0; cyc < 200 && (m0_req || m1_req); cyc++) begin
            @(negedge clk);
            if (m0_ack) m0_req = 1'b0;
            if (m1_ack) m1_req = 1'b0;
            if (bus_ce_o && grant == 2'b01 && m0_req) begin
                m0_addr = $urandom; m0_wdata = $urandom; m0_we = 1'($urandom_range(0, 1));
            end
            if (bus_ce_o && grant == 2'b10 && m1_req) begin
                m1_addr = $urandom; m1_wdata = $urandom; m1_we = 1'($urandom_range(0, 1));
            end
        end
        check("round_done", 32'(m0_req | m1_req), 32'h0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // ram responder: follows the plan in expected grant order, pokes stray acks when idle
    initial begin
        txn_t p;
        int   n;
        bus_ack_i  = 1'b0;
        bus_data_i = '0;
        forever begin
            @(negedge clk);
            if (ram_en && bus_ce_o && plan_q.size() != 0) begin
                p = plan_q.pop_front();
                n = 0;
                while (bus_ce_o && n < 300) begin
                    check("bus_grant", 32'(grant), p.owner ? 32'h2 : 32'h1);
                    check("bus_addr", bus_addr_o, p.addr);
                    check("bus_we", 32'(bus_we_o), 32'(p.we));
                    check("bus_data", bus_data_o, p.wdata);
                    bus_ack_i  = (n == p.lat);
                    bus_data_i = (n == p.lat) ? p.bus_rd : $urandom;
                    n++;
                    @(negedge clk);
                end
                check("ce_cycles", n, (p.lat >= TIMEOUT) ? TIMEOUT : p.lat + 1);
                check("ack_latency", 32'(p.owner ? m1_ack : m0_ack), 32'h1);
            end else if (ram_en && bus_ce_o) begin
                n_chk++;
                n_fail++;
                $display("FAIL unplanned_bus_cycle: got ce=1 with empty plan at %0t", $time);
            end
            bus_ack_i  = ram_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_data_i = $urandom;
        end
    end

    // scoreboard monitor
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                check("ack_onehot", 32'(m0_ack & m1_ack), 32'h0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b expected none at %0t",
                             m0_ack, m1_ack, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_owner", 32'(m1_ack), 32'(e.owner));
                    check("rdata", e.owner ? m1_rdata : m0_rdata, exp_rdata(e));
                    check("err", 32'(e.owner ? m1_err : m0_err), 32'(e.lat >= TIMEOUT));
                    check("done_grant", 32'(grant), e.owner ? 32'h2 : 32'h1);
                    check("done_ce", 32'(bus_ce_o), 32'h0);
                end
            end
            if (m0_err && !m0_ack) check("m0_err_qual", 32'(m0_err), 32'(m0_ack));
            if (m1_err && !m1_ack) check("m1_err_qual", 32'(m1_err), 32'(m1_ack));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1);
    end

    task automatic check_quiet(input string tag);
        check({tag, "_ce"}, 32'(bus_ce_o), 32'h0);
        check({tag, "_we"}, 32'(bus_we_o), 32'h0);
        check({tag, "_addr"}, bus_addr_o, 32'h0);
        check({tag, "_data"}, bus_data_o, 32'h0);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_acks"}, 32'({m1_ack, m0_ack}), 32'h0);
        check({tag, "_errs"}, 32'({m1_err, m0_err}), 32'h0);
    endtask

    initial begin
        txn_t z;
        z = mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0);
        rst = 1'b0;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_we = 1'b0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_we = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("reset_m0_rdata", m0_rdata, 32'h0);
        check("reset_m1_rdata", m1_rdata, 32'h0);
        rst = 1'b1;
        ram_en = 1'b1;

        // stray acks while idle must not start anything
        repeat (6) begin
            @(negedge clk);
            check("idle_ce", 32'(bus_ce_o), 32'h0);
            check("idle_acks", 32'({m1_ack, m0_ack, grant}), 32'h0);
        end

        run_round(1'b1, 1'b0, mk(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2), z);
        run_round(1'b1, 1'b1, rand_txn(1'b0), rand_txn(1'b1));
        run_round(1'b1, 1'b1, rand_txn(1'b0), rand_txn(1'b1));
        run_round(1'b0, 1'b1, z, mk(1'b1, 32'h100, 32'h12345678, 1'b1, 32'hA5A5A5A5, 3));
        run_round(1'b1, 1'b0, mk(1'b0, 32'h40, 32'h0, 1'b0, 32'h11111111, TIMEOUT + 10), z);
        run_round(1'b1, 1'b0, mk(1'b0, 32'h44, 32'h0, 1'b0, 32'h22222222, 1), z);
        run_round(1'b0, 1'b1, mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0),
                  mk(1'b1, 32'h48, 32'h0, 1'b0, 32'h33333333, TIMEOUT - 1));

        // asynchronous reset in the middle of a BUSY transaction
        ram_en = 1'b0;
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 32'h80; m0_wdata = 32'h5; m0_we = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_ce", 32'(bus_ce_o), 32'h1);
        #3 rst = 1'b0;
        #1 check_quiet("midreset");
        m0_req = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("held_reset");
        rst = 1'b1;
        ram_en = 1'b1;
        last_srv = 1'b1;
        run_round(1'b1, 1'b1, rand_txn(1'b0), rand_txn(1'b1));

        for (int r = 0; r < 80; r++) begin
            int m;
            m = int'($urandom_range(1, 3));
            run_round(m[0], m[1], rand_txn(1'b0), rand_txn(1'b1));
        end

        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("plan_q_drained", 32'(plan_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter sharing the single SRAM bus port of the `ram` controller between instruction fetch (m0) and data access (m1). It performs round-robin arbitration, registers the winning request onto the bus and holds it until the `ram` acknowledge. It returns read data plus a one-cycle acknowledge to the winner, and aborts with an error flag if the `ram` controller fails to acknowledge within a bounded number of cycles. It sits between the CPU memory stages and `ram`.

## Interface
- `TIMEOUT`, 16: max cycles in BUSY before abort; legal range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `m0_req` in 1: fetch request; held high until `m0_ack`.
- `m0_addr` in 32: byte address; only [21:2] is meaningful to `ram`.
- `m0_wdata` in 32: write data.
- `m0_we` in 1: 1 = write, 0 = read.
- `m0_rdata` out 32: read data, valid while `m0_ack`.
- `m0_ack` out 1: one-cycle completion pulse.
- `m0_err` out 1: high with `m0_ack` on timeout abort.
- `m1_*`: identical set for the data requester.
- `bus_addr_o` out 32: to `ram` address.
- `bus_data_o` out 32: to `ram` write data.
- `bus_data_i` in 32: from `ram` read data.
- `bus_ce_o` out 1: to `ram` chip enable.
- `bus_we_o` out 1: to `ram` write enable.
- `bus_ack_i` in 1: from `ram` acknowledge.
- `grant` out 2: one-hot owner during BUSY/DONE, 00 otherwise.

## Operation
- States:
  - IDLE: bus outputs 0.
  - BUSY: `bus_ce_o`=1, registered request driven.
  - DONE: ack pulse to the owner, bus outputs 0.
- IDLE→BUSY when any `mX_req`=1. On that edge, latch the winner's addr/wdata/we into bus registers and set `grant`.
- Round-robin arbitration: a single request wins outright. Simultaneous requests go to the requester not served last. `last` resets to 1, so m0 wins the first tie.
- BUSY→DONE on `bus_ack_i`=1. Capture `bus_data_i` into the owner's rdata register; for writes, capture 0. Clear `err`. Update `last` to the owner.
- BUSY→DONE when the timeout counter reaches `TIMEOUT`-1 without ack. Capture rdata=0 and set `err`=1. `last` updates as normal.
- DONE→IDLE unconditionally. `mX_ack` is high only in DONE and only for the owner. `mX_err` mirrors `err` qualified by ack.
- Timeout counter: 8-bit. Cleared on entering BUSY, increments each BUSY cycle, saturates.
- `bus_ack_i` in IDLE or DONE is ignored.
- Request inputs are sampled only at the IDLE edge. Changes during BUSY are ignored, since the bus is driven from registers.
- A requester whose req is still high in the IDLE cycle after its ack is treated as a new request.
- Reset, asynchronous, mid-transaction included:
  - state IDLE, `last`=1, counter 0.
  - all outputs 0.
  - no ack issued for the aborted transaction.

## Timing
- All outputs are registered; no combinational input→output paths.
- Fixed 3-cycle skeleton:
  - req seen in IDLE at edge E0;
  - `bus_ce_o`=1 from E0 until the ack edge Ek;
  - `mX_ack` high for the single cycle after Ek.
- Latency from req sampled to ack visible = 1 + (cycles until `bus_ack_i`) + 1.
- Minimum back-to-back period per transaction: 3 cycles (IDLE, BUSY, DONE).
- Timeout abort: `bus_ce_o` high exactly `TIMEOUT` cycles; ack appears 1 cycle later.
- A `bus_ack_i` arriving on the same edge the timeout would fire is accepted as a success, with err=0.

## Structure
- Package `ram_arb_pkg`: state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), `ADDR_W`=32, `DATA_W`=32, grant encodings `GNT_M0`=2'b01, `GNT_M1`=2'b10.
- Sub-module `rr_pick2`: combinational two-way round-robin picker (`req[1:0]`, `last` → one-hot `win`). Kept separate so it can be reused for a third requester later.
- Top level holds the FSM, bus registers, rdata/err registers and the timeout counter.

## Test plan
- m0 read 0x00000010 alone; `ram` acks 2 cycles after `bus_ce_o` rises with 0xDEADBEEF → `m0_ack` 1 cycle, `m0_rdata`=0xDEADBEEF, `m0_err`=0, `grant`=01 during transaction.
- m0 and m1 request on the same cycle after reset → m0 served first, then m1. Repeat with both held → grants alternate 01,10,01,10.
- m1 write addr 0x00000100, data 0x12345678 → `bus_we_o`=1, `bus_addr_o`/`bus_data_o` match and stay stable while m1 changes `m1_addr` mid-BUSY. `m1_rdata`=0 on ack.
- `ram` never acks, TIMEOUT=16 → `bus_ce_o` high exactly 16 cycles, then `m0_ack`=1 with `m0_err`=1, `m0_rdata`=0. The next request proceeds normally.
- `rst` pulled low during BUSY → all outputs 0 immediately, no ack pulse. After release, a pending m0 and m1 tie is granted to m0.
- `bus_ack_i` pulsed during IDLE with no requests → no state change, no ack outputs.
